// File: rtl/seg_mux_driver.sv
// Multiplexed seven-segment driver: time-slices NUM_DIGITS hex digits onto shared active-low cathodes.
// Optional leading-zero suppression is built when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic                      load,
  output logic [7:0]                seg_cat,
  output logic [NUM_DIGITS-1:0]     seg_an,
  output logic                      frame_pulse
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         act_value_q, act_value_d, pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] seg_an_q, seg_an_d;
  logic [7:0]            seg_cat_q, seg_cat_d;
  logic                  frame_pulse_q, frame_pulse_d;
  logic                  tick, boundary;
  logic [NUM_DIGITS-1:0] eff_blank;

  // Segment pattern g..a, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h27;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit goes dark while it and everything above it is zero, unless a decimal point is lit at or above it.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VW-1:0] v,
                                                     input logic [NUM_DIGITS-1:0] d);
    logic all_zero;
    logic exempt;
    lz_mask  = '0;
    all_zero = 1'b1;
    exempt   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (v[4*i +: 4] == 4'h0);
      exempt     = exempt | d[i];
      lz_mask[i] = all_zero & ~exempt;
    end
  endfunction
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    tick     = (presc_q == PRE_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    presc_d  = tick ? '0 : presc_q + PW'(1);

    idx_d = idx_q;
    if (tick) idx_d = boundary ? '0 : idx_q + IW'(1);

    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;

    // Content only swaps at a frame boundary; a load landing on that edge bypasses the pending stage.
    if (boundary) begin
      if (load) begin
        act_value_d  = value;
        act_dp_d     = dp;
        act_blank_d  = blank;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_value_d  = pend_value_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    eff_blank = act_blank_d | lz_mask(act_value_d, act_dp_d);
`else
    eff_blank = act_blank_d;
`endif

    // Drivers are decoded from the next index and content so they move on the same edge as idx.
    seg_an_d  = seg_an_q;
    seg_cat_d = seg_cat_q;
    if (tick) begin
      seg_an_d  = '1;
      seg_cat_d = 8'hFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((idx_d == IW'(i)) && !eff_blank[i]) begin
          seg_an_d[i] = 1'b0;
          seg_cat_d   = {~act_dp_d[i], glyph(act_value_d[4*i +: 4])};
        end
      end
    end

    frame_pulse_d = boundary;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= IDX_LAST;
      act_value_q   <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      seg_an_q      <= '1;
      seg_cat_q     <= 8'hFF;
      frame_pulse_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      act_value_q   <= act_value_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      seg_an_q      <= seg_an_d;
      seg_cat_q     <= seg_cat_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign seg_an      = seg_an_q;
  assign seg_cat     = seg_cat_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver (4 digits, 4 cycles per slot): table of load vectors plus
// hand sequences for double load, boundary-edge load and mid-frame reset; slot scoreboard.
module tb_seg_mux_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    blank;
  logic          load;
  logic [7:0]    seg_cat;
  logic [3:0]    seg_an;
  logic          frame_pulse;

  always #5 clk = ~clk;

  seg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .load        (load),
    .seg_cat     (seg_cat),
    .seg_an      (seg_an),
    .frame_pulse (frame_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         slot;
    logic [3:0] an;
    logic [7:0] cat;
    logic       fp;
  } slot_t;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] cat;
    logic [3:0][3:0] an;
  } vec_t;

  slot_t sb[$];
  int    cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Slot s starts on posedge number RD*s after reset release; compare once at its start, once mid-slot.
  slot_t cur;
  logic  cur_ok = 1'b0;
  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      if (cyc % RD == 0) begin
        cur_ok = 1'b0;
        while (sb.size() > 0 && sb[0].slot < cyc / RD) begin
          checks++;
          errors++;
          $display("FAIL slot%0d_missed: got no compare expected one", sb[0].slot);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].slot == cyc / RD) begin
          cur    = sb.pop_front();
          cur_ok = 1'b1;
          check($sformatf("slot%0d_an", cur.slot), 32'(seg_an), 32'(cur.an));
          check($sformatf("slot%0d_cat", cur.slot), 32'(seg_cat), 32'(cur.cat));
          check($sformatf("slot%0d_fp", cur.slot), 32'(frame_pulse), 32'(cur.fp));
        end
      end else if (cyc % RD == 2 && cur_ok) begin
        check($sformatf("slot%0d_an_hold", cur.slot), 32'(seg_an), 32'(cur.an));
        check($sformatf("slot%0d_cat_hold", cur.slot), 32'(seg_cat), 32'(cur.cat));
        check($sformatf("slot%0d_fp_low", cur.slot), 32'(frame_pulse), 32'(0));
      end
    end
  end

  task automatic push_slot(input int s, input logic [3:0] an, input logic [7:0] cat, input logic fp);
    slot_t r;
    r.slot = s;
    r.an   = an;
    r.cat  = cat;
    r.fp   = fp;
    sb.push_back(r);
  endtask

  // Frame f occupies slots 4f+1 .. 4f+4, digit 0 first.
  task automatic push_frame(input int f, input logic [3:0][7:0] cats, input logic [3:0][3:0] ans);
    for (int i = 0; i < ND; i++) push_slot(4 * f + 1 + i, ans[i], cats[i], i == 0);
  endtask

  task automatic push_uniform(input int f, input logic [7:0] cat);
    push_frame(f, {cat, cat, cat, cat}, {4'h7, 4'hB, 4'hD, 4'hE});
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 2000 && cyc != n; k++) @(negedge clk);
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc%0d: got cyc %0d expected %0d", n, cyc, n);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  vec_t vecs[NV];

  initial begin
    int fa, fb, fh;

    vecs[0] = '{16'h1A2F, 4'b0100, 4'b0000, {8'hF9, 8'h08, 8'hA4, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    vecs[1] = '{16'h0000, 4'b0000, 4'b1000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[2] = '{16'h0040, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'h99, 8'hC0}, {4'hF, 4'hF, 4'hD, 4'hE}};
    vecs[6] = '{16'h0005, 4'b0100, 4'b0000, {8'hFF, 8'h40, 8'hC0, 8'h92}, {4'hF, 4'hB, 4'hD, 4'hE}};
`else
    vecs[1] = '{16'h0000, 4'b0000, 4'b1000, {8'hFF, 8'hC0, 8'hC0, 8'hC0}, {4'hF, 4'hB, 4'hD, 4'hE}};
    vecs[2] = '{16'h0040, 4'b0000, 4'b0000, {8'hC0, 8'hC0, 8'h99, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[6] = '{16'h0005, 4'b0100, 4'b0000, {8'hC0, 8'h40, 8'hC0, 8'h92}, {4'h7, 4'hB, 4'hD, 4'hE}};
`endif
    vecs[3] = '{16'hCDE7, 4'b1111, 4'b0000, {8'h27, 8'h21, 8'h06, 8'h78}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[4] = '{16'h3456, 4'b0000, 4'b0101, {8'hB0, 8'hFF, 8'h92, 8'hFF}, {4'h7, 4'hF, 4'hD, 4'hF}};
    vecs[5] = '{16'h6BF8, 4'b0000, 4'b0000, {8'h82, 8'h83, 8'h8E, 8'h80}, {4'h7, 4'hB, 4'hD, 4'hE}};

    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    dp    = '0;
    blank = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(seg_an), 32'hF);
    check("reset_cat", 32'(seg_cat), 32'hFF);
    check("reset_fp", 32'(frame_pulse), 32'h0);

    rst_n = 1'b1;
    push_slot(1, 4'hE, 8'hC0, 1'b1);
    for (int k = 1; k < RD; k++) begin
      wait_cyc(k);
      check($sformatf("pre_tick%0d_an", k), 32'(seg_an), 32'hF);
      check($sformatf("pre_tick%0d_cat", k), 32'(seg_cat), 32'hFF);
    end
    wait_cyc(RD + 1);
    check("first_fp_one_cycle", 32'(frame_pulse), 32'h0);

    // Vector v is loaded mid-frame 1+v and must first appear in frame 2+v.
    for (int v = 0; v < NV; v++) begin
      wait_cyc(16 * (1 + v) + 6);
      push_frame(2 + v, vecs[v].cat, vecs[v].an);
      do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
    end

    // Two loads in one frame: the later one wins.
    fa = NV + 1;
    push_uniform(fa + 1, 8'hA4);
    wait_cyc(16 * fa + 6);
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_cyc(16 * fa + 10);
    do_load(16'h2222, 4'b0000, 4'b0000);

    // Pending 7777 is superseded by a load on the boundary edge, which must also clear pending.
    fb = fa + 1;
    wait_cyc(16 * fb + 6);
    do_load(16'h7777, 4'b0000, 4'b0000);
    wait_cyc(16 * (fb + 1) + 3);
    push_uniform(fb + 1, 8'h92);
    push_uniform(fb + 2, 8'h92);
    do_load(16'h5555, 4'b0000, 4'b0000);

    // Reset mid-slot with a pending load: outputs go dark at once and 8888 never shows.
    fh = fb + 3;
    wait_cyc(16 * fh + 6);
    do_load(16'h8888, 4'b0000, 4'b0000);
    wait_cyc(16 * fh + 9);
    rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(seg_an), 32'hF);
    check("async_rst_cat", 32'(seg_cat), 32'hFF);
    check("async_rst_fp", 32'(frame_pulse), 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_an", 32'(seg_an), 32'hF);
    rst_n = 1'b1;
    push_slot(1, 4'hE, 8'hC0, 1'b1);
    push_slot(5, 4'hE, 8'hC0, 1'b1);
    wait_cyc(RD * 6);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
